// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serializes WORD_W-bit words MSB-first and runs an
// overlapping PAT_W-bit pattern match on the resulting bit stream.
// Matches may span word boundaries and IDLE gaps. Each match produces a
// one-cycle pulse and bumps a saturating counter. A sticky irq is raised
// when the counter reaches a programmable threshold.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   enable              allows new words to be accepted
//   cfg_we, cfg_pattern pattern load (IDLE only); pattern MSB is the oldest bit
//   in_valid/in_ready/in_data  word handshake
//   serial_out          bit currently presented to the detector
//   busy                high while shifting
//   match_pulse         registered one-cycle pulse per match
//   match_count         saturating match counter
//   irq_thresh          irq threshold (0 disables)
//   irq_clr             clears irq and match_count
//   irq                 sticky interrupt
module seq_detect_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              serial_out,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    input  logic [CNT_W-1:0]  irq_thresh,
    input  logic              irq_clr,
    output logic              irq
);
    localparam int IDXW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int BSW  = $clog2(PAT_W + 1);

    localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(WORD_W - 1);
    localparam logic [BSW-1:0]   BS_MAX   = BSW'(PAT_W);
    localparam logic [BSW-1:0]   BS_THR   = BSW'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pattern_q, pattern_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [BSW-1:0]    bits_q, bits_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              mp_q, mp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              irq_q, irq_d;

    logic              hs;
    logic              last_bit;
    logic              hit;
    logic [PAT_W-1:0]  hist_next;
    logic [CNT_W-1:0]  cnt_inc;

    assign last_bit   = (state_q == SHIFT) && (idx_q == IDX_LAST);
    assign in_ready   = enable && ((state_q == IDLE) || last_bit);
    assign serial_out = (state_q == SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
    assign busy       = (state_q == SHIFT);
    assign hs         = in_valid && in_ready;

    // Window including the bit on serial_out now; it becomes hist on this edge.
    assign hist_next  = {hist_q[PAT_W-2:0], serial_out};
    // bits_q counts bits already in hist, so >= PAT_W-1 means the window is full.
    assign hit        = (state_q == SHIFT) && (hist_next == pattern_q) && (bits_q >= BS_THR);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        bits_d    = bits_q;
        idx_d     = idx_q;
        sreg_d    = sreg_q;
        mp_d      = hit;
        cnt_d     = cnt_q;
        irq_d     = irq_q;

        case (state_q)
            IDLE: begin
                if (hs) begin
                    sreg_d  = in_data;
                    idx_d   = '0;
                    state_d = SHIFT;
                end else if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    hist_d    = '0;
                    bits_d    = '0;
                end
            end
            SHIFT: begin
                hist_d = hist_next;
                sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                idx_d  = idx_q + IDXW'(1);
                if (bits_q != BS_MAX) bits_d = bits_q + BSW'(1);
                if (last_bit) begin
                    // Back-to-back reload keeps the stream gapless.
                    if (hs) begin
                        sreg_d = in_data;
                        idx_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear beats a coincident increment; the pulse itself still fires.
        if (irq_clr) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else if (hit) begin
            cnt_d = cnt_inc;
            if ((irq_thresh != '0) && (cnt_inc == irq_thresh)) irq_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            hist_q    <= '0;
            bits_q    <= '0;
            idx_q     <= '0;
            sreg_q    <= '0;
            mp_q      <= 1'b0;
            cnt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            bits_q    <= bits_d;
            idx_q     <= idx_d;
            sreg_q    <= sreg_d;
            mp_q      <= mp_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_d;
        end
    end

    assign match_pulse = mp_q;
    assign match_count = cnt_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl. Inputs change and outputs are sampled
// on the falling edge; sample i is taken between edges E0+i and E0+i+1,
// where E0 is the handshake edge.
module tb_seq_detect_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       cfg_we;
    logic [3:0] cfg_pattern;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       serial_out;
    logic       busy;
    logic       match_pulse;
    logic [7:0] match_count;
    logic [7:0] irq_thresh;
    logic       irq_clr;
    logic       irq;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mp_v, busy_v, rdy_v;

    always #5 clock = ~clock;

    seq_detect_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .serial_out(serial_out), .busy(busy), .match_pulse(match_pulse),
        .match_count(match_count), .irq_thresh(irq_thresh),
        .irq_clr(irq_clr), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample(input int i);
        @(negedge clock);
        mp_v[i]   = match_pulse;
        busy_v[i] = busy;
        rdy_v[i]  = in_ready;
    endtask

    // Load a pattern (clears history) and zero the counter/irq, from IDLE.
    task automatic prep(input logic [3:0] p);
        cfg_pattern = p;
        cfg_we      = 1'b1;
        irq_clr     = 1'b1;
        @(negedge clock);
        cfg_we  = 1'b0;
        irq_clr = 1'b0;
        mp_v = '0; busy_v = '0; rdy_v = '0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; cfg_we = 1'b0; cfg_pattern = 4'h0;
        in_valid = 1'b0; in_data = 8'h00; irq_thresh = 8'h00; irq_clr = 1'b0;
        mp_v = '0; busy_v = '0; rdy_v = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_serial", {31'b0, serial_out}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mp", {31'b0, match_pulse}, 32'd0);
        chk("rst_count", {24'b0, match_count}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        reset = 1'b1; enable = 1'b1;
        @(negedge clock);
        chk("idle_ready", {31'b0, in_ready}, 32'd1);

        // Reset in the middle of shifting 8'hFF
        in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clock);
        in_valid = 1'b0;
        chk("ff_busy", {31'b0, busy}, 32'd1);
        chk("ff_serial", {31'b0, serial_out}, 32'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0; enable = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_serial", {31'b0, serial_out}, 32'd0);
        chk("midrst_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clock);
        reset = 1'b1; enable = 1'b1;
        for (int i = 0; i < 10; i++) sample(i);
        chk("postrst_mp", mp_v & 32'h3FF, 32'h0);
        chk("postrst_busy", busy_v & 32'h3FF, 32'h0);
        chk("postrst_ready", {31'b0, in_ready}, 32'd1);

        // Pattern 1101, word DA: matches complete on bits 3 and 6
        prep(4'b1101);
        in_valid = 1'b1; in_data = 8'hDA;
        for (int i = 0; i < 12; i++) begin
            sample(i);
            if (i == 0) in_valid = 1'b0;
        end
        chk("da_mp", mp_v & 32'hFFF, 32'h090);
        chk("da_busy", busy_v & 32'hFFF, 32'h0FF);
        chk("da_ready", rdy_v & 32'hFFF, 32'hF80);
        chk("da_count", {24'b0, match_count}, 32'd2);

        // Back-to-back 03,40: single match across the word boundary
        prep(4'b1101);
        in_valid = 1'b1; in_data = 8'h03;
        for (int i = 0; i < 18; i++) begin
            sample(i);
            if (i == 0) in_data = 8'h40;
            if (i == 8) in_valid = 1'b0;
        end
        chk("b2b_mp", mp_v & 32'h3FFFF, 32'h00400);
        chk("b2b_busy", busy_v & 32'h3FFFF, 32'h0FFFF);
        chk("b2b_count", {24'b0, match_count}, 32'd1);

        // Pattern 0000 on word 00: first possible match is bit 3
        prep(4'b0000);
        in_valid = 1'b1; in_data = 8'h00;
        for (int i = 0; i < 12; i++) begin
            sample(i);
            if (i == 0) in_valid = 1'b0;
        end
        chk("zero_mp", mp_v & 32'hFFF, 32'h1F0);
        chk("zero_count", {24'b0, match_count}, 32'd5);

        // Pattern 1010, threshold 3, two AA words; clear coincides with 4th match
        prep(4'b1010);
        irq_thresh = 8'd3;
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 18; i++) begin
            sample(i);
            if (i == 7) chk("aa_irq_pre", {31'b0, irq}, 32'd0);
            if (i == 8) begin
                in_valid = 1'b0;
                chk("aa_irq_set", {31'b0, irq}, 32'd1);
                chk("aa_count3", {24'b0, match_count}, 32'd3);
            end
            if (i == 9) irq_clr = 1'b1;
            if (i == 10) begin
                irq_clr = 1'b0;
                chk("aa_clr_mp", {31'b0, match_pulse}, 32'd1);
                chk("aa_clr_count", {24'b0, match_count}, 32'd0);
                chk("aa_clr_irq", {31'b0, irq}, 32'd0);
            end
        end
        chk("aa_mp", mp_v & 32'h3FFFF, 32'h15550);
        chk("aa_count_end", {24'b0, match_count}, 32'd3);
        chk("aa_irq_again", {31'b0, irq}, 32'd1);
        irq_thresh = 8'd0;

        // cfg_we during SHIFT ignored; enable dropped at bit 2
        prep(4'b1101);
        in_valid = 1'b1; in_data = 8'hDA;
        for (int i = 0; i < 12; i++) begin
            sample(i);
            if (i == 0) in_valid = 1'b0;
            if (i == 2) begin cfg_we = 1'b1; cfg_pattern = 4'b0000; enable = 1'b0; end
            if (i == 3) cfg_we = 1'b0;
            if (i == 8) begin in_valid = 1'b1; in_data = 8'h00; end
        end
        chk("dis_mp", mp_v & 32'hFFF, 32'h090);
        chk("dis_busy", busy_v & 32'hFFF, 32'h0FF);
        chk("dis_ready", rdy_v & 32'hFFF, 32'h000);
        chk("dis_count", {24'b0, match_count}, 32'd2);
        in_valid = 1'b0;
        enable = 1'b1;
        #1;
        chk("reen_ready", {31'b0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
